rob_ar_scheduler: RTL and testbench

Shares one reorder_buffer slave port between NUM_REQ requesters. Round-robin arbitrates requester AR requests onto the ROB AR slave port and blocks any ID already outstanding, because ROB data storage is indexed by ID. Limits outstanding reads to MAX_OUTSTANDING. Steers the in-order ROB R stream back to the originating requester.

---
 rtl/rob_sched_pkg.sv | 20 ++
 rtl/rob_src_fifo.sv | 62 ++++++
 rtl/rob_ar_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_rob_ar_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_sched_pkg.sv
// Shared types and constants for the ROB AR scheduler.
// ID_WIDTH/NUM_IDS describe the ROB ID space; SRC_WIDTH holds a requester index (up to 8).
package rob_sched_pkg;

  localparam int unsigned ID_WIDTH  = 4;
  localparam int unsigned NUM_IDS   = 16;
  localparam int unsigned SRC_WIDTH = 3;

  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } sched_state_e;

  // One entry per outstanding read: which requester asked, and with which ID.
  typedef struct packed {
    logic [SRC_WIDTH-1:0] src;
    logic [ID_WIDTH-1:0]  id;
  } src_entry_t;

endpackage

// File: rtl/rob_src_fifo.sv
// Source-tracking FIFO: records {requester, id} for every accepted AR in issue order so
// the in-order R stream can be steered back to its requester.
// Ports: clk, rst (async, active-high); push_i/push_data_i write one entry; pop_i removes
// the head; head_o is the oldest entry; full_o/empty_o are occupancy flags.
module rob_src_fifo
  import rob_sched_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  src_entry_t push_data_i,
  input  logic       pop_i,
  output src_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  src_entry_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  // Explicit wrap so depths that are not a power of two still cycle correctly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; entries are only read when the count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rob_ar_scheduler.sv
// Shares one reorder-buffer slave port between NUM_REQ requesters.
// AR side: round-robin arbitration, blocking IDs already outstanding and capping the
// number of outstanding reads; the granted AR is presented to the ROB from a register.
// R side: the in-order ROB R stream is steered to the requester at the source FIFO head.
// Ports: clk, rst (async, active-high); req_* requester AR/R channels (IDs packed 4 bits
// per requester); rob_* ROB slave AR/R channels; outstanding_o live count; err_o sticky
// protocol error (R with nothing outstanding, or R ID not matching the expected head).
module rob_ar_scheduler
  import rob_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ*4-1:0]  req_arid_i,
  input  logic [NUM_REQ-1:0]    req_arvalid_i,
  output logic [NUM_REQ-1:0]    req_arready_o,
  output logic [DATA_WIDTH-1:0] req_rdata_o,
  output logic [3:0]            req_rid_o,
  output logic [NUM_REQ-1:0]    req_rvalid_o,
  input  logic [NUM_REQ-1:0]    req_rready_i,
  output logic [3:0]            rob_arid_o,
  output logic                  rob_arvalid_o,
  input  logic                  rob_arready_i,
  input  logic [DATA_WIDTH-1:0] rob_rdata_i,
  input  logic [3:0]            rob_rid_i,
  input  logic                  rob_rvalid_i,
  output logic                  rob_rready_o,
  output logic [4:0]            outstanding_o,
  output logic                  err_o
);

  localparam logic [4:0] MaxOut = 5'(MAX_OUTSTANDING);

  sched_state_e         state_q;
  logic [SRC_WIDTH-1:0] rr_q;
  logic [ID_WIDTH-1:0]  ar_id_q;
  logic                 ar_valid_q;
  logic [NUM_IDS-1:0]   id_busy_q, id_busy_d;
  logic [4:0]           outstanding_q, outstanding_d;
  logic                 err_q, err_d;

  logic                 fifo_full, fifo_empty;
  src_entry_t           head, push_entry;

  logic [NUM_REQ-1:0]   eligible;
  logic [2*NUM_REQ-1:0] elig_dbl, elig_rot;
  logic                 found, grant, sel_rready, r_hs;
  logic [SRC_WIDTH-1:0] winner;
  logic [ID_WIDTH-1:0]  win_id;

  function automatic logic [SRC_WIDTH-1:0] wrap_add(input logic [SRC_WIDTH-1:0] base,
                                                    input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return SRC_WIDTH'(sum);
  endfunction

  always_comb begin
    eligible = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible[k] = req_arvalid_i[k] && !id_busy_q[req_arid_i[ID_WIDTH*k +: ID_WIDTH]] &&
                    (outstanding_q < MaxOut) && !fifo_full;
    end
  end

  // Rotate so bit 0 is the rr pointer; the lowest set bit is the winner.
  assign elig_dbl = {eligible, eligible};
  assign elig_rot = elig_dbl >> rr_q;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig_rot[i]) begin
        found  = 1'b1;
        winner = wrap_add(rr_q, unsigned'(i));
      end
    end
  end

  assign grant = found && (state_q == StIdle);

  always_comb begin
    win_id        = '0;
    req_arready_o = '0;
    sel_rready    = 1'b0;
    req_rvalid_o  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == SRC_WIDTH'(k)) begin
        win_id           = req_arid_i[ID_WIDTH*k +: ID_WIDTH];
        req_arready_o[k] = grant && !rst;
      end
      if (head.src == SRC_WIDTH'(k)) begin
        sel_rready      = req_rready_i[k];
        req_rvalid_o[k] = rob_rvalid_i && !fifo_empty && !rst;
      end
    end
  end

  assign rob_rready_o  = sel_rready && !fifo_empty && !rst;
  assign r_hs          = rob_rvalid_i && rob_rready_o;
  assign req_rdata_o   = rob_rdata_i;
  assign req_rid_o     = rob_rid_i;
  assign rob_arvalid_o = ar_valid_q;
  assign rob_arid_o    = ar_id_q;
  assign outstanding_o = outstanding_q;
  assign err_o         = err_q;

  assign push_entry.src = winner;
  assign push_entry.id  = win_id;

  rob_src_fifo #(
    .Depth (MAX_OUTSTANDING)
  ) u_src_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (grant),
    .push_data_i (push_entry),
    .pop_i       (r_hs),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      ar_id_q    <= '0;
      ar_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant) begin
            ar_id_q    <= win_id;
            ar_valid_q <= 1'b1;
            rr_q       <= wrap_add(winner, 1);
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (rob_arready_i) begin
            ar_valid_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Clear before set: a grant and a release in the same cycle both take effect.
  always_comb begin
    id_busy_d = id_busy_q;
    if (r_hs)  id_busy_d[rob_rid_i] = 1'b0;
    if (grant) id_busy_d[win_id]    = 1'b1;
    case ({grant, r_hs})
      2'b10:   outstanding_d = outstanding_q + 5'd1;
      2'b01:   outstanding_d = outstanding_q - 5'd1;
      default: outstanding_d = outstanding_q;
    endcase
    err_d = err_q || (rob_rvalid_i && fifo_empty) || (r_hs && (rob_rid_i != head.id));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_busy_q     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      id_busy_q     <= id_busy_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_rob_ar_scheduler.sv
// Bench for rob_ar_scheduler: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against a queue-based reference model.
module tb_rob_ar_scheduler;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR*4-1:0] req_arid;
  logic [NR-1:0]   req_arvalid, req_arready, req_rvalid, req_rready;
  logic [DW-1:0]   req_rdata, rob_rdata;
  logic [3:0]      req_rid, rob_arid, rob_rid;
  logic            rob_arvalid, rob_arready, rob_rvalid, rob_rready;
  logic [4:0]      outstanding;
  logic            err;

  always #5 clk = ~clk;

  rob_ar_scheduler #(
    .NUM_REQ         (NR),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_arid_i    (req_arid),
    .req_arvalid_i (req_arvalid),
    .req_arready_o (req_arready),
    .req_rdata_o   (req_rdata),
    .req_rid_o     (req_rid),
    .req_rvalid_o  (req_rvalid),
    .req_rready_i  (req_rready),
    .rob_arid_o    (rob_arid),
    .rob_arvalid_o (rob_arvalid),
    .rob_arready_i (rob_arready),
    .rob_rdata_i   (rob_rdata),
    .rob_rid_i     (rob_rid),
    .rob_rvalid_i  (rob_rvalid),
    .rob_rready_o  (rob_rready),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: outstanding reads as a queue of {src,id}, a busy set, rr pointer,
  // and one pending ROB AR.
  typedef struct { int src; int id; } ent_t;
  typedef struct { int id; int data; } rob_ent_t;
  ent_t     m_q[$];
  bit       m_busy[16];
  int       m_rr;
  bit       m_issue;
  int       m_arid;
  bit       m_err;
  rob_ent_t rob_q[$];        // ROB-side responder state (stimulus only)
  logic [NR-1:0] acc;        // requester accepts seen in the last cycle

  always @(negedge clk) begin
    int            win, k, hid;
    logic [NR-1:0] exp_arready, exp_rvalid;
    bit            exp_rready, hs;
    if (rst) begin
      m_q.delete();
      rob_q.delete();
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      m_rr = 0; m_issue = 1'b0; m_arid = 0; m_err = 1'b0;
      acc = '0;
      chk("rst_arready", req_arready, 0);
      chk("rst_rvalid", req_rvalid, 0);
      chk("rst_arvalid", rob_arvalid, 0);
      chk("rst_rready", rob_rready, 0);
      chk("rst_outst", outstanding, 0);
      chk("rst_err", err, 0);
    end else begin
      win = -1;
      if (!m_issue) begin
        for (int i = 0; i < NR; i++) begin
          k = (m_rr + i) % NR;
          if (win < 0 && req_arvalid[k] && !m_busy[req_arid[4*k +: 4]] && m_q.size() < MAXO)
            win = k;
        end
      end
      exp_arready = (win >= 0) ? NR'(1 << win) : '0;
      exp_rvalid  = '0;
      exp_rready  = 1'b0;
      if (m_q.size() > 0) begin
        if (rob_rvalid) exp_rvalid = NR'(1 << m_q[0].src);
        exp_rready = req_rready[m_q[0].src];
      end
      chk("m_arready", req_arready, exp_arready);
      chk("m_arvalid", rob_arvalid, m_issue);
      if (m_issue) chk("m_arid", rob_arid, m_arid);
      chk("m_rvalid", req_rvalid, exp_rvalid);
      chk("m_rready", rob_rready, exp_rready);
      chk("m_rdata", req_rdata, rob_rdata);
      chk("m_rid", req_rid, rob_rid);
      chk("m_outst", outstanding, m_q.size());
      chk("m_err", err, m_err);

      hs = rob_rvalid && exp_rready;
      if (rob_rvalid && m_q.size() == 0) m_err = 1'b1;
      if (hs) begin
        if (int'(rob_rid) != m_q[0].id) m_err = 1'b1;
        m_busy[rob_rid] = 1'b0;
        void'(m_q.pop_front());
      end
      if (win >= 0) begin
        hid = int'(req_arid[4*win +: 4]);
        m_busy[hid] = 1'b1;
        m_q.push_back('{src: win, id: hid});
        m_rr    = (win + 1) % NR;
        m_issue = 1'b1;
        m_arid  = hid;
      end else if (m_issue && rob_arready) begin
        m_issue = 1'b0;
      end

      acc = req_arready & req_arvalid;
      if (rob_arvalid && rob_arready)
        rob_q.push_back('{id: int'(rob_arid), data: int'($urandom_range(0, 255))});
      if (rob_rvalid && rob_rready && rob_q.size() > 0) void'(rob_q.pop_front());
    end
  end

  bit auto_req, fixed_ids, auto_rob, eager;

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    for (int k = 0; k < NR; k++) if (acc[k]) req_arvalid[k] = 1'b0;
    if (auto_req) begin
      for (int k = 0; k < NR; k++) begin
        if (!req_arvalid[k] && (eager || $urandom_range(0, 2) == 0)) begin
          req_arvalid[k]    = 1'b1;
          req_arid[4*k +: 4] = fixed_ids ? 4'(k) : 4'($urandom_range(0, 15));
        end
      end
    end
    if (auto_rob) begin
      rob_arready = eager ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (rob_q.size() > 0 && (eager || $urandom_range(0, 2) != 0)) begin
        rob_rvalid = 1'b1;
        rob_rid    = 4'(rob_q[0].id);
        rob_rdata  = 8'(rob_q[0].data);
      end else begin
        rob_rvalid = 1'b0;
        rob_rid    = 4'($urandom_range(0, 15));
        rob_rdata  = 8'($urandom_range(0, 255));
      end
      req_rready = eager ? '1 : NR'($urandom_range(0, 15));
    end
  endtask

  task automatic clear_inputs();
    auto_req = 0; fixed_ids = 0; auto_rob = 0; eager = 0;
    req_arid = '0; req_arvalid = '0; req_rready = '0;
    rob_arready = 0; rob_rdata = '0; rob_rid = '0; rob_rvalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int gr_idx[5];
  int gr_cyc[5];
  int ngr;

  initial begin
    clear_inputs();
    // Valid requests during reset must not be accepted.
    req_arvalid = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_arready", req_arready, 0);
    chk("reset_outst", outstanding, 0);
    chk("reset_err", err, 0);
    do_reset();

    // Single request: req0 ID 3, data 0xA5.
    req_arvalid[0] = 1'b1; req_arid[3:0] = 4'd3;
    step();
    chk("single_accept", acc, 4'b0001);
    chk("single_arvalid", rob_arvalid, 1);
    chk("single_arid", rob_arid, 3);
    chk("single_outst1", outstanding, 1);
    rob_arready = 1'b1;
    step();
    rob_arready = 1'b0;
    chk("single_ar_done", rob_arvalid, 0);
    chk("single_outst_hold", outstanding, 1);
    rob_rvalid = 1'b1; rob_rid = 4'd3; rob_rdata = 8'hA5; req_rready = '1;
    #1;
    chk("single_rvalid", req_rvalid, 4'b0001);
    chk("single_rdata", req_rdata, 8'hA5);
    chk("single_rready", rob_rready, 1);
    step();
    rob_rvalid = 1'b0;
    chk("single_outst0", outstanding, 0);

    // Round-robin with fixed IDs 0..3 and an always-ready ROB.
    do_reset();
    for (int k = 0; k < NR; k++) req_arid[4*k +: 4] = 4'(k);
    req_arvalid = '1; rob_arready = 1'b1; req_rready = '1;
    auto_req = 1; fixed_ids = 1; auto_rob = 1; eager = 1;
    ngr = 0;
    for (int c = 0; c < 40 && ngr < 5; c++) begin
      step();
      if (acc != 0) begin
        for (int k = 0; k < NR; k++) if (acc[k]) gr_idx[ngr] = k;
        gr_cyc[ngr] = cycle;
        ngr++;
      end
    end
    chk("rr_count", ngr, 5);
    for (int i = 0; i < 5 && i < ngr; i++) begin
      chk("rr_order", gr_idx[i], i % NR);
      if (i > 0) chk("rr_gap", gr_cyc[i] - gr_cyc[i-1], 2);
    end

    // ID collision: req0 and req1 both use ID 5.
    do_reset();
    req_arvalid = 4'b0011; req_arid[3:0] = 4'd5; req_arid[7:4] = 4'd5;
    rob_arready = 1'b1; req_rready = '1;
    step(); chk("coll_first", acc, 4'b0001);
    step(); chk("coll_issue", acc, 0);
    step(); chk("coll_block", acc, 0);
    rob_rvalid = 1'b1; rob_rid = 4'd5; rob_rdata = 8'h3C;
    step(); chk("coll_hs_cycle", acc, 0);
    rob_rvalid = 1'b0;
    step(); chk("coll_second", acc, 4'b0010);

    // Credit limit: 16 distinct IDs with no R returned.
    do_reset();
    rob_arready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_arvalid[0] = 1'b1; req_arid[3:0] = 4'(i);
      step(); chk("credit_grant", acc, 4'b0001);
      step();
    end
    chk("credit_full", outstanding, 16);
    req_arvalid[1] = 1'b1; req_arid[7:4] = 4'd0;
    repeat (3) begin
      step(); chk("credit_stall", acc, 0);
    end
    chk("credit_full_hold", outstanding, 16);
    rob_rvalid = 1'b1; rob_rid = 4'd0; rob_rdata = 8'h11; req_rready = '1;
    step(); chk("credit_hs_cycle", acc, 0);
    rob_rvalid = 1'b0;
    step(); chk("credit_release", acc, 4'b0010);
    step(); chk("credit_refill", outstanding, 16);

    // R steering with backpressure from req2.
    do_reset();
    rob_arready = 1'b1;
    req_arvalid[2] = 1'b1; req_arid[11:8] = 4'd7;
    step(); chk("steer_grant", acc, 4'b0100);
    step();
    rob_arready = 1'b0;
    rob_rvalid = 1'b1; rob_rid = 4'd7; rob_rdata = 8'h5A; req_rready = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("steer_rready_low", rob_rready, 0);
      chk("steer_rvalid", req_rvalid, 4'b0100);
      step();
    end
    req_rready = '1;
    #1;
    chk("steer_rready_high", rob_rready, 1);
    step();
    rob_rvalid = 1'b0;
    chk("steer_outst0", outstanding, 0);

    // Errors: R valid with nothing outstanding; err is sticky.
    chk("err_pre", err, 0);
    rob_rvalid = 1'b1; rob_rid = 4'd9;
    #1;
    chk("err_rready", rob_rready, 0);
    step();
    rob_rvalid = 1'b0;
    chk("err_set", err, 1);
    repeat (3) step();
    chk("err_sticky", err, 1);

    // Reset while an AR is waiting in ISSUE.
    req_arvalid[0] = 1'b1; req_arid[3:0] = 4'd1; rob_arready = 1'b0;
    step();
    chk("mid_grant", acc, 4'b0001);
    chk("mid_issue", rob_arvalid, 1);
    rst = 1'b1;
    req_arvalid[1] = 1'b1; req_arid[7:4] = 4'd2;
    rob_rvalid = 1'b1; rob_rid = 4'd1; req_rready = '1;
    #1;
    chk("mid_arvalid", rob_arvalid, 0);
    chk("mid_arready", req_arready, 0);
    chk("mid_rvalid", req_rvalid, 0);
    chk("mid_rready", rob_rready, 0);
    chk("mid_outst", outstanding, 0);
    chk("mid_err", err, 0);
    step();

    // Randomized traffic against the model, then drain.
    do_reset();
    auto_req = 1; auto_rob = 1;
    repeat (3000) step();
    auto_req = 0; req_arvalid = '0; eager = 1;
    repeat (200) step();
    chk("drain_outst", outstanding, 0);
    chk("drain_err", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
